// File: rtl/bcnn_pkg.sv
// Shared types, constants and helpers for the BCNN feature pipeline.
package bcnn_pkg;

  localparam int KERNEL_SIZE   = 3;
  localparam int KERNEL_BITS   = KERNEL_SIZE * KERNEL_SIZE;
  localparam int SUM_WIDTH_DEF = 4;

  typedef logic [KERNEL_BITS-1:0] window_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  // Number of window positions that agree with the kernel.
  function automatic logic [3:0] xnor_popcount(input window_t win, input window_t weights);
    logic [3:0] cnt;
    window_t    match;
    match = ~(win ^ weights);
    cnt   = 4'd0;
    for (int i = 0; i < KERNEL_BITS; i++) begin
      cnt = cnt + {3'd0, match[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/bcnn_threshold.sv
// Registered binarization stage: out = (in >= THRESHOLD), held between valid pulses.
module bcnn_threshold
  import bcnn_pkg::*;
#(
  parameter int WIDTH     = SUM_WIDTH_DEF,
  parameter int THRESHOLD = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             out,
  output logic             out_valid
);

  // Compare register; the activation only updates on a valid input.
  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= (in >= WIDTH'(THRESHOLD));
      end
    end
  end

endmodule

// File: rtl/bcnn_conv3x3_bin_top.sv
// Streaming binary 3x3 XNOR-popcount convolution over a raster 1-bit image,
// followed by a registered threshold stage.
module bcnn_conv3x3_bin_top
  import bcnn_pkg::*;
#(
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28,
  parameter int KERNEL_SIZE = 3,
  parameter int SUM_WIDTH   = SUM_WIDTH_DEF,
  parameter int THRESHOLD   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pixel_in,
  input  logic                 valid_in,
  input  logic [8:0]           weight_bits,
  output logic [SUM_WIDTH-1:0] popcount,
  output logic                 valid_out,
  output logic                 bin_out,
  output logic                 bin_valid
);

  localparam int COL_W = clog2(IMG_WIDTH);
  localparam int ROW_W = clog2(IMG_HEIGHT);

  logic [COL_W-1:0]     col_r;
  logic [ROW_W-1:0]     row_r;
  logic                 line_top_r [IMG_WIDTH];
  logic                 line_mid_r [IMG_WIDTH];
  window_t              win_r;
  window_t              win_next_s;
  logic                 accept_s;
  logic                 last_col_s;
  logic                 last_row_s;
  logic                 complete_s;
  logic [SUM_WIDTH-1:0] popcount_r;
  logic                 valid_out_r;

  assign accept_s   = valid_in & ~reset;
  assign last_col_s = (col_r == COL_W'(IMG_WIDTH - 1));
  assign last_row_s = (row_r == ROW_W'(IMG_HEIGHT - 1));
  assign complete_s = (row_r >= ROW_W'(2)) && (col_r >= COL_W'(2));

  // Shift the window one column left; the new right column is top/mid taps plus the live pixel.
  always_comb begin
    win_next_s = win_r;
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      win_next_s[r*3 + 0] = win_r[r*3 + 1];
      win_next_s[r*3 + 1] = win_r[r*3 + 2];
    end
    win_next_s[2] = line_top_r[col_r];
    win_next_s[5] = line_mid_r[col_r];
    win_next_s[8] = pixel_in;
  end

  // Raster column/row counters, wrapping at the end of the frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_r <= {COL_W{1'b0}};
      row_r <= {ROW_W{1'b0}};
    end else if (valid_in) begin
      if (last_col_s) begin
        col_r <= {COL_W{1'b0}};
        if (last_row_s) begin
          row_r <= {ROW_W{1'b0}};
        end else begin
          row_r <= row_r + ROW_W'(1);
        end
      end else begin
        col_r <= col_r + COL_W'(1);
      end
    end
  end

  // Line buffers: the mid row ages into the top row as the new pixel replaces it.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      line_top_r[col_r] <= line_mid_r[col_r];
      line_mid_r[col_r] <= pixel_in;
    end
  end

  // Window register.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_r <= {KERNEL_BITS{1'b0}};
    end else if (valid_in) begin
      win_r <= win_next_s;
    end
  end

  // Popcount register; holds its value between window pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      popcount_r  <= {SUM_WIDTH{1'b0}};
      valid_out_r <= 1'b0;
    end else begin
      valid_out_r <= valid_in & complete_s;
      if (valid_in && complete_s) begin
        popcount_r <= SUM_WIDTH'(xnor_popcount(win_next_s, weight_bits));
      end
    end
  end

  assign popcount  = popcount_r;
  assign valid_out = valid_out_r;

  bcnn_threshold #(
    .WIDTH     (SUM_WIDTH),
    .THRESHOLD (THRESHOLD)
  ) u_threshold (
    .clk       (clk),
    .reset     (reset),
    .in        (popcount_r),
    .in_valid  (valid_out_r),
    .out       (bin_out),
    .out_valid (bin_valid)
  );

endmodule

// File: tb/tb_bcnn_conv3x3_bin_top.sv
// Directed bench for bcnn_conv3x3_bin_top: whole frames streamed, window results collected and compared.
module tb_bcnn_conv3x3_bin_top;

  localparam int W    = 28;
  localparam int H    = 28;
  localparam int NWIN = (W - 2) * (H - 2);

  logic       clk = 1'b0;
  logic       reset;
  logic       pixel_in;
  logic       valid_in;
  logic [8:0] weight_bits;
  logic [3:0] popcount;
  logic       valid_out;
  logic       bin_out;
  logic       bin_valid;

  int  n_vec = 0;
  int  n_err = 0;
  bit  img [H][W];
  int  pop_q[$];
  bit  bin_q[$];
  bit  binlag_q[$];
  int  stall_viol = 0;
  logic vo_prev  = 1'b0;
  logic acc_prev = 1'b0;

  always #5 clk = ~clk;

  bcnn_conv3x3_bin_top #(
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .KERNEL_SIZE (3),
    .SUM_WIDTH   (4),
    .THRESHOLD   (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_in    (pixel_in),
    .valid_in    (valid_in),
    .weight_bits (weight_bits),
    .popcount    (popcount),
    .valid_out   (valid_out),
    .bin_out     (bin_out),
    .bin_valid   (bin_valid)
  );

  // Collect pulses on the falling edge; inputs are stable then.
  always @(negedge clk) begin
    if (valid_out === 1'b1) pop_q.push_back(int'(popcount));
    if (bin_valid === 1'b1) begin
      bin_q.push_back(bin_out);
      binlag_q.push_back(vo_prev);
    end
    if (valid_out === 1'b1 && acc_prev !== 1'b1) stall_viol <= stall_viol + 1;
    vo_prev  <= valid_out;
    acc_prev <= valid_in & ~reset;
  end

  function automatic int model_pop(input int r0, input int c0, input logic [8:0] w);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if (img[r0+i][c0+j] == w[i*3+j]) cnt++;
    return cnt;
  endfunction

  task automatic push_pixel(input bit p);
    pixel_in = p;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input int gap_pct);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 3));
        push_pixel(img[r][c]);
      end
  endtask

  task automatic start_clean;
    idle(4);
    pop_q.delete();
    bin_q.delete();
    binlag_q.delete();
  endtask

  task automatic test_reset;
    n_vec++; if (popcount !== 4'd0) begin n_err++; $display("FAIL reset_popcount got=%0d want=0", popcount); end
    n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid_out got=%b want=0", valid_out); end
    n_vec++; if (bin_out !== 1'b0) begin n_err++; $display("FAIL reset_bin_out got=%b want=0", bin_out); end
    n_vec++; if (bin_valid !== 1'b0) begin n_err++; $display("FAIL reset_bin_valid got=%b want=0", bin_valid); end
  endtask

  // All-zero frame then all-ones frame, back to back across the frame wrap.
  task automatic test_uniform;
    int exp_p;
    bit exp_b;
    weight_bits = 9'h1FF;
    start_clean();
    foreach (img[r, c]) img[r][c] = 1'b0;
    send_frame(0);
    foreach (img[r, c]) img[r][c] = 1'b1;
    send_frame(0);
    idle(4);
    n_vec++; if (pop_q.size() != 2*NWIN) begin n_err++; $display("FAIL uniform_count got=%0d want=%0d", pop_q.size(), 2*NWIN); end
    for (int i = 0; i < pop_q.size() && i < 2*NWIN; i++) begin
      exp_p = (i < NWIN) ? 0 : 9;
      n_vec++; if (pop_q[i] != exp_p) begin n_err++; $display("FAIL uniform_pop[%0d] got=%0d want=%0d", i, pop_q[i], exp_p); end
    end
    for (int i = 0; i < bin_q.size() && i < 2*NWIN; i++) begin
      exp_b = (i < NWIN) ? 1'b0 : 1'b1;
      n_vec++; if (bin_q[i] !== exp_b) begin n_err++; $display("FAIL uniform_bin[%0d] got=%b want=%b", i, bin_q[i], exp_b); end
    end
  endtask

  task automatic test_xnor;
    weight_bits = 9'h000;
    start_clean();
    foreach (img[r, c]) img[r][c] = 1'b0;
    send_frame(0);
    idle(4);
    n_vec++; if (pop_q.size() != NWIN) begin n_err++; $display("FAIL xnor_count got=%0d want=%0d", pop_q.size(), NWIN); end
    for (int i = 0; i < pop_q.size() && i < NWIN; i++) begin
      n_vec++; if (pop_q[i] != 9) begin n_err++; $display("FAIL xnor_pop[%0d] got=%0d want=9", i, pop_q[i]); end
    end
  endtask

  // Even top-left parity means the corner pixel is 0, leaving 4 ones in the window.
  task automatic test_checker;
    int exp_p;
    weight_bits = 9'h1FF;
    start_clean();
    foreach (img[r, c]) img[r][c] = bit'((r + c) & 1);
    send_frame(0);
    idle(4);
    n_vec++; if (pop_q.size() != NWIN) begin n_err++; $display("FAIL checker_count got=%0d want=%0d", pop_q.size(), NWIN); end
    for (int i = 0; i < pop_q.size() && i < NWIN; i++) begin
      exp_p = (((i / (W-2)) + (i % (W-2))) % 2 == 0) ? 4 : 5;
      n_vec++; if (pop_q[i] != exp_p) begin n_err++; $display("FAIL checker_pop[%0d] got=%0d want=%0d", i, pop_q[i], exp_p); end
    end
  endtask

  task automatic test_single_pixel;
    int r0, c0, exp_p;
    weight_bits = 9'h1FF;
    start_clean();
    foreach (img[r, c]) img[r][c] = 1'b0;
    img[5][5] = 1'b1;
    send_frame(0);
    idle(4);
    n_vec++; if (pop_q.size() != NWIN) begin n_err++; $display("FAIL single_count got=%0d want=%0d", pop_q.size(), NWIN); end
    for (int i = 0; i < pop_q.size() && i < NWIN; i++) begin
      r0 = i / (W-2);
      c0 = i % (W-2);
      exp_p = (r0 >= 3 && r0 <= 5 && c0 >= 3 && c0 <= 5) ? 1 : 0;
      n_vec++; if (pop_q[i] != exp_p) begin n_err++; $display("FAIL single_pop(%0d,%0d) got=%0d want=%0d", r0, c0, pop_q[i], exp_p); end
    end
    for (int i = 0; i < bin_q.size() && i < NWIN; i++) begin
      n_vec++; if (bin_q[i] !== 1'b0) begin n_err++; $display("FAIL single_bin[%0d] got=%b want=0", i, bin_q[i]); end
    end
  endtask

  // Column sums 1,0,1,2,1 over rows 0..2 give first-row windows 2,3,4.
  task automatic test_threshold;
    int exp_p;
    int lag_bad;
    weight_bits = 9'h1FF;
    start_clean();
    foreach (img[r, c]) img[r][c] = 1'b0;
    img[0][0] = 1'b1; img[0][2] = 1'b1; img[0][3] = 1'b1; img[1][3] = 1'b1; img[0][4] = 1'b1;
    send_frame(0);
    idle(4);
    n_vec++; if (pop_q.size() != NWIN || bin_q.size() != NWIN) begin
      n_err++; $display("FAIL thr_count got=%0d/%0d want=%0d", pop_q.size(), bin_q.size(), NWIN);
    end else begin
      n_vec++; if (pop_q[0] != 2) begin n_err++; $display("FAIL thr_pop0 got=%0d want=2", pop_q[0]); end
      n_vec++; if (pop_q[1] != 3) begin n_err++; $display("FAIL thr_pop1 got=%0d want=3", pop_q[1]); end
      n_vec++; if (pop_q[2] != 4) begin n_err++; $display("FAIL thr_pop2 got=%0d want=4", pop_q[2]); end
      n_vec++; if (bin_q[0] !== 1'b0) begin n_err++; $display("FAIL thr_bin0 got=%b want=0", bin_q[0]); end
      n_vec++; if (bin_q[1] !== 1'b1) begin n_err++; $display("FAIL thr_bin1 got=%b want=1", bin_q[1]); end
      n_vec++; if (bin_q[2] !== 1'b1) begin n_err++; $display("FAIL thr_bin2 got=%b want=1", bin_q[2]); end
      for (int i = 0; i < NWIN; i++) begin
        exp_p = model_pop(i / (W-2), i % (W-2), weight_bits);
        n_vec++; if (bin_q[i] !== bit'(exp_p >= 3)) begin n_err++; $display("FAIL thr_bin[%0d] got=%b want=%b", i, bin_q[i], exp_p >= 3); end
      end
    end
    lag_bad = 0;
    foreach (binlag_q[i]) if (binlag_q[i] !== 1'b1) lag_bad++;
    n_vec++; if (lag_bad != 0) begin n_err++; $display("FAIL thr_bin_spacing got=%0d late pulses want=0", lag_bad); end
  endtask

  task automatic test_gaps;
    int exp_p;
    int stall0;
    weight_bits = 9'h0B5;
    start_clean();
    stall0 = stall_viol;
    foreach (img[r, c]) img[r][c] = bit'($urandom_range(0, 1));
    send_frame(25);
    idle(4);
    n_vec++; if (pop_q.size() != NWIN) begin n_err++; $display("FAIL gaps_count got=%0d want=%0d", pop_q.size(), NWIN); end
    for (int i = 0; i < pop_q.size() && i < NWIN; i++) begin
      exp_p = model_pop(i / (W-2), i % (W-2), weight_bits);
      n_vec++; if (pop_q[i] != exp_p) begin n_err++; $display("FAIL gaps_pop[%0d] got=%0d want=%0d", i, pop_q[i], exp_p); end
    end
    n_vec++; if (stall_viol != stall0) begin n_err++; $display("FAIL gaps_stall_pulse got=%0d want=0", stall_viol - stall0); end
  endtask

  task automatic test_midframe_reset;
    int exp_p;
    weight_bits = 9'h1C3;
    start_clean();
    foreach (img[r, c]) img[r][c] = bit'($urandom_range(0, 1));
    for (int k = 0; k < 400; k++) push_pixel(img[k / W][k % W]);
    reset    = 1'b1;
    pixel_in = 1'b1;
    valid_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin reset = 1'b0; valid_in = 1'b0; end
      @(posedge clk); #1;
      n_vec++; if (popcount !== 4'd0) begin n_err++; $display("FAIL mrst_popcount[%0d] got=%0d want=0", k, popcount); end
      n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL mrst_valid_out[%0d] got=%b want=0", k, valid_out); end
      n_vec++; if (bin_out !== 1'b0) begin n_err++; $display("FAIL mrst_bin_out[%0d] got=%b want=0", k, bin_out); end
      n_vec++; if (bin_valid !== 1'b0) begin n_err++; $display("FAIL mrst_bin_valid[%0d] got=%b want=0", k, bin_valid); end
    end
    start_clean();
    foreach (img[r, c]) img[r][c] = bit'($urandom_range(0, 1));
    send_frame(0);
    idle(4);
    n_vec++; if (pop_q.size() != NWIN) begin n_err++; $display("FAIL mrst_count got=%0d want=%0d", pop_q.size(), NWIN); end
    for (int i = 0; i < pop_q.size() && i < NWIN; i++) begin
      exp_p = model_pop(i / (W-2), i % (W-2), weight_bits);
      n_vec++; if (pop_q[i] != exp_p) begin n_err++; $display("FAIL mrst_pop[%0d] got=%0d want=%0d", i, pop_q[i], exp_p); end
    end
  endtask

  initial begin
    reset       = 1'b1;
    pixel_in    = 1'b0;
    valid_in    = 1'b0;
    weight_bits = 9'h000;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_uniform();
    test_xnor();
    test_checker();
    test_single_pixel();
    test_threshold();
    test_gaps();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bcnn_conv3x3_bin_top.md
# bcnn_conv3x3_bin_top

Streaming binary 3x3 convolution with thresholding, placed at the front of the BCNN feature pipeline. It accepts a 1-bit image in raster order, one pixel per accepted cycle. For every complete 3x3 window it computes the XNOR-popcount against a 9-bit kernel. It then emits a 1-bit binarized activation by comparing that count with a fixed threshold.

## Interface
Parameters:
- IMG_WIDTH, 28, pixels per row (≥3)
- IMG_HEIGHT, 28, rows per frame (≥3)
- KERNEL_SIZE, 3, window edge; only 3 is supported
- SUM_WIDTH, 4, popcount width; must be ≥ clog2(KERNEL_SIZE²+1)
- THRESHOLD, 3, binarization threshold

Ports:
- clk  in  1  rising-edge clock, single clock domain
- reset  in  1  synchronous, active-high
- pixel_in  in  1  input pixel bit
- valid_in  in  1  pixel_in is accepted this cycle
- weight_bits  in  9  kernel; bit r*3+c = window row r (0 = top), col c (0 = left); must be held stable for the whole frame
- popcount  out  SUM_WIDTH  XNOR-match count for the current window, range 0..9
- valid_out  out  1  popcount is valid (one-cycle pulse per window)
- bin_out  out  1  binarized activation
- bin_valid  out  1  bin_out is valid

## Operation
- Raster order: pixel index = row*IMG_WIDTH + col.
- Internal column and row counters advance only on valid_in=1.
- When valid_in=0, no state changes.
- Two IMG_WIDTH-deep 1-bit line buffers hold the previous two rows.
- A 3x3 shift window is fed from the line-buffer taps plus pixel_in.
- A window is complete when the accepted pixel has row ≥ 2 and col ≥ 2.
  - Its top-left corner is pixel (row−2, col−2).
  - Windows never straddle row boundaries.
- popcount = number of positions where window bit == weight bit, i.e. popcount(~(window ^ weight_bits)), zero-extended to SUM_WIDTH.
- bin_out = (popcount ≥ THRESHOLD), evaluated on the registered popcount.
- Outputs per frame: (IMG_HEIGHT−2)*(IMG_WIDTH−2) = 676 at the defaults, in raster order of the top-left corners.
- After pixel (IMG_HEIGHT−1, IMG_WIDTH−1) is accepted, both counters wrap to 0. The next pixel starts a new frame, and no window mixes rows from two frames.
- Reset:
  - Clears the counters, popcount, valid_out, bin_out, bin_valid and the shift window.
  - Line buffer contents need not be cleared.
  - Reset in mid-frame abandons that frame; the next accepted pixel is (0,0).

## Timing
- Reset values: popcount=0, valid_out=0, bin_out=0, bin_valid=0.
- Latency:
  - popcount and valid_out are registered 1 cycle after the edge that accepts the completing pixel.
  - bin_out and bin_valid are registered 1 cycle after popcount and valid_out (2 cycles after the accepting edge).
- valid_out is high for exactly one cycle per completed window. With valid_in held high, a row yields IMG_WIDTH−2 consecutive pulses followed by 2 idle cycles.
- popcount holds its value between pulses. The same holds for bin_out between bin_valid pulses.
- There is no backpressure: the consumer must accept each pulse.
- If reset is asserted in the same cycle as valid_in=1, reset wins and the pixel is dropped.

## Structure
- Shared package `bcnn_pkg` holds:
  - KERNEL_SIZE=3 and KERNEL_BITS=9
  - SUM_WIDTH default and a clog2 helper
  - a window type (logic [8:0])
- Sub-module `bcnn_threshold`:
  - parameters WIDTH and THRESHOLD
  - ports clk, reset, in, in_valid, out, out_valid
  - one registered compare stage
- The top contains the counters, line buffers, window, XNOR-popcount and output registers.

## Test plan
- Kernel 9'h1FF, all-zero 28x28 frame → 676 valid_out pulses, each popcount=0 and bin_out=0. Then an all-ones frame → popcount=9 and bin_out=1 for all 676.
- Kernel 9'h000, all-zero frame → popcount=9 everywhere, confirming XNOR semantics. Kernel 9'h1FF, checkerboard frame → popcount alternates 5/4.
- Kernel 9'h1FF, single 1 at pixel (5,5):
  - popcount=1 exactly at the 9 windows with top-left corners (3..5, 3..5), 0 elsewhere.
  - THRESHOLD=3, so bin_out=0 everywhere.
  - Also checks row-boundary correctness: no nonzero count at col 0/1 windows.
- Threshold boundary: windows with popcount 2, 3 and 4 → bin_out 0, 1, 1 respectively. Check 1-cycle spacing between valid_out and bin_valid.
- Random valid_in gaps during the frame → same popcount sequence as a gap-free stream, and no pulses during stalls.
- Reset at pixel 400, then a full frame → exactly 676 pulses with correct values, and all outputs 0 during and just after reset.
